// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel clock-enable divider, display counters,
// sync/blank, and a lookahead fetch position split into tile coordinates.
`timescale 1ns/1ps
module video_timing_gen #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned TILE_LOG2 = 4,
    parameter int unsigned LOOKAHEAD = 3,
    parameter int unsigned SYNC_POL  = 0,
    parameter int unsigned CW        = 11
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic                    enable,
    output logic                    pix_ce,
    output logic                    VGA_CLK,
    output logic                    VGA_HS,
    output logic                    VGA_VS,
    output logic                    VGA_BLANK_N,
    output logic                    video_on,
    output logic [CW-1:0]           h_count,
    output logic [CW-1:0]           v_count,
    output logic [CW-1:0]           h_ahead,
    output logic [CW-1:0]           v_ahead,
    output logic [CW-TILE_LOG2-1:0] tile_col,
    output logic [CW-TILE_LOG2-1:0] tile_row,
    output logic [TILE_LOG2-1:0]    sub_x,
    output logic [TILE_LOG2-1:0]    sub_y,
    output logic                    line_start,
    output logic                    frame_start,
    output logic [15:0]             frame_count
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_LO   = H_ACTIVE + H_FP;
    localparam int unsigned HS_HI   = H_ACTIVE + H_FP + H_SYNC - 1;
    localparam int unsigned VS_LO   = V_ACTIVE + V_FP;
    localparam int unsigned VS_HI   = V_ACTIVE + V_FP + V_SYNC - 1;
    localparam int unsigned DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic SYNC_ACT   = 1'(SYNC_POL);
    localparam logic SYNC_IDLE  = ~SYNC_ACT;
    localparam logic PIX_CE_RST = (CLK_DIV == 1);

    logic [DW-1:0] r_div;
    logic          r_pix_ce;
    logic [CW-1:0] r_h_count;
    logic [CW-1:0] r_v_count;
    logic [CW-1:0] r_h_ahead;
    logic [CW-1:0] r_v_ahead;
    logic          r_hs;
    logic          r_vs;
    logic          r_video_on;
    logic          r_line_start;
    logic          r_frame_start;
    logic [15:0]   r_frame_count;

    logic          w_tick;
    logic [DW-1:0] w_div_next;
    logic          w_pix_ce_next;
    logic          w_h_wrap;
    logic          w_v_wrap;
    logic          w_frame_wrap;
    logic [CW-1:0] w_h_next;
    logic [CW-1:0] w_v_next;
    logic          w_ha_wrap;
    logic          w_va_wrap;
    logic [CW-1:0] w_ha_next;
    logic [CW-1:0] w_va_next;
    logic          w_hs_next;
    logic          w_vs_next;
    logic          w_von_next;

    assign w_tick = enable & r_pix_ce;

    // Divider phase and the registered clock-enable that decodes its last phase.
    always_comb begin
        w_div_next    = '0;
        w_pix_ce_next = 1'b0;
        if (r_div != DW'(CLK_DIV - 1)) begin
            w_div_next = r_div + DW'(1);
        end
        w_pix_ce_next = (w_div_next == DW'(CLK_DIV - 1));
    end

    // Next display position plus the sync/blank state that position will carry.
    always_comb begin
        w_h_wrap     = (r_h_count == CW'(H_TOTAL - 1));
        w_v_wrap     = (r_v_count == CW'(V_TOTAL - 1));
        w_frame_wrap = w_h_wrap & w_v_wrap;
        w_h_next     = r_h_count + CW'(1);
        w_v_next     = r_v_count;
        if (w_h_wrap) begin
            w_h_next = '0;
            w_v_next = w_v_wrap ? '0 : r_v_count + CW'(1);
        end
        w_hs_next  = ((w_h_next >= CW'(HS_LO)) && (w_h_next <= CW'(HS_HI))) ? SYNC_ACT : SYNC_IDLE;
        w_vs_next  = ((w_v_next >= CW'(VS_LO)) && (w_v_next <= CW'(VS_HI))) ? SYNC_ACT : SYNC_IDLE;
        w_von_next = (w_h_next < CW'(H_ACTIVE)) && (w_v_next < CW'(V_ACTIVE));
    end

    // Fetch position runs the same raster walk, started LOOKAHEAD pixels ahead.
    always_comb begin
        w_ha_wrap = (r_h_ahead == CW'(H_TOTAL - 1));
        w_va_wrap = (r_v_ahead == CW'(V_TOTAL - 1));
        w_ha_next = r_h_ahead + CW'(1);
        w_va_next = r_v_ahead;
        if (w_ha_wrap) begin
            w_ha_next = '0;
            w_va_next = w_va_wrap ? '0 : r_v_ahead + CW'(1);
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_div    <= '0;
            r_pix_ce <= PIX_CE_RST;
        end else if (enable) begin
            r_div    <= w_div_next;
            r_pix_ce <= w_pix_ce_next;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_h_count  <= '0;
            r_v_count  <= '0;
            r_h_ahead  <= CW'(LOOKAHEAD);
            r_v_ahead  <= '0;
            r_hs       <= SYNC_IDLE;
            r_vs       <= SYNC_IDLE;
            r_video_on <= 1'b0;
        end else if (w_tick) begin
            r_h_count  <= w_h_next;
            r_v_count  <= w_v_next;
            r_h_ahead  <= w_ha_next;
            r_v_ahead  <= w_va_next;
            r_hs       <= w_hs_next;
            r_vs       <= w_vs_next;
            r_video_on <= w_von_next;
        end
    end

    // Pulses last one HCLK regardless of enable; the counter self-holds when idle.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_line_start  <= w_tick & w_h_wrap;
            r_frame_start <= w_tick & w_frame_wrap;
            r_frame_count <= r_frame_count + 16'(w_tick & w_frame_wrap);
        end
    end

    assign pix_ce      = r_pix_ce;
    assign VGA_CLK     = r_pix_ce;
    assign VGA_HS      = r_hs;
    assign VGA_VS      = r_vs;
    assign video_on    = r_video_on;
    assign VGA_BLANK_N = r_video_on;
    assign h_count     = r_h_count;
    assign v_count     = r_v_count;
    assign h_ahead     = r_h_ahead;
    assign v_ahead     = r_v_ahead;
    assign tile_col    = r_h_ahead[CW-1:TILE_LOG2];
    assign tile_row    = r_v_ahead[CW-1:TILE_LOG2];
    assign sub_x       = r_h_ahead[TILE_LOG2-1:0];
    assign sub_y       = r_v_ahead[TILE_LOG2-1:0];
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign frame_count = r_frame_count;

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- CLK_DIV, 2, HCLK cycles per pixel, 1..16
- TILE_LOG2, 4, log2 of tile edge in pixels, 1..5
- LOOKAHEAD, 3, pixel ticks by which the fetch position leads the display position, 0..H_TOTAL-1
- SYNC_POL, 0, sync active level (0 = active-low)
- CW, 11, coordinate width

REQ-002 Ports SHALL be (name, direction, width, meaning):
- HCLK, in, 1, sole clock
- HRESETn, in, 1, asynchronous active-low reset
- enable, in, 1, run; low freezes all state
- pix_ce, out, 1, pixel clock enable, also drives VGA_CLK
- VGA_CLK, out, 1, equals pix_ce
- VGA_HS, out, 1, horizontal sync
- VGA_VS, out, 1, vertical sync
- VGA_BLANK_N, out, 1, equals video_on
- video_on, out, 1, display position inside the active area
- h_count, out, CW, display x
- v_count, out, CW, display y
- h_ahead, out, CW, fetch x
- v_ahead, out, CW, fetch y
- tile_col, out, CW-TILE_LOG2, h_ahead >> TILE_LOG2
- tile_row, out, CW-TILE_LOG2, v_ahead >> TILE_LOG2
- sub_x, out, TILE_LOG2, h_ahead mod tile size
- sub_y, out, TILE_LOG2, v_ahead mod tile size
- line_start, out, 1, one-HCLK pulse
- frame_start, out, 1, one-HCLK pulse
- frame_count, out, 16, completed frames

Function
REQ-003 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP; both SHALL fit in CW bits.
REQ-004 A divider SHALL count 0..CLK_DIV-1 on each HCLK while enable=1; pix_ce=1 exactly in the HCLK cycle where the divider equals CLK_DIV-1; CLK_DIV=1 gives pix_ce constantly 1 while enabled.
REQ-005 All registered state SHALL advance only on HCLK edges with enable=1 and pix_ce=1 (a "tick"); enable=0 SHALL hold every output, including the divider phase.
REQ-006 On a tick, h_count SHALL increment; at H_TOTAL-1 it SHALL wrap to 0 and v_count SHALL increment; at (H_TOTAL-1, V_TOTAL-1) both SHALL wrap to 0.
REQ-007 (h_ahead, v_ahead) SHALL always equal the raster position LOOKAHEAD ticks after (h_count, v_count), wrapping across line and frame boundaries; LOOKAHEAD=0 makes them identical.
REQ-008 tile_col, tile_row, sub_x and sub_y SHALL be derived from h_ahead and v_ahead in the same cycle (no extra latency).
REQ-009 VGA_HS SHALL be at the active level iff h_count is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
REQ-010 VGA_VS SHALL be at the active level iff v_count is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1].
REQ-011 video_on SHALL be 1 iff h_count < H_ACTIVE and v_count < V_ACTIVE.
REQ-012 Sync and video_on SHALL be registered and aligned with the h_count/v_count value they describe, with zero relative skew.
REQ-013 line_start SHALL be 1 for exactly the one HCLK cycle following a tick that sets h_count to 0.
REQ-014 frame_start SHALL be 1 for exactly the one HCLK cycle following a tick that sets (h_count, v_count) to (0,0); on that tick line_start SHALL also pulse.
REQ-015 frame_count SHALL increment on the tick that wraps the frame, modulo 2^16.

Reset
REQ-016 HRESETn=0 SHALL, asynchronously, set the following and hold them until release:
- divider = 0
- h_count = v_count = 0
- h_ahead = LOOKAHEAD, v_ahead = 0
- frame_count = 0
- line_start = frame_start = 0
- video_on = 0
- VGA_HS and VGA_VS inactive (1 when SYNC_POL=0)
REQ-017 Reset asserted mid-frame SHALL discard all position state; after release, counting SHALL resume from the REQ-016 values, and the first tick SHALL produce h_count=1 with no frame_start pulse.

Verification
REQ-018 The bench SHALL cover the following scenarios:
- Defaults, run 2x800x525 HCLK from reset: VGA_HS low exactly for h_count 656..751; VGA_VS low for v_count 490..491; frame_start pulses once, with frame_count=1.
- Defaults: h_count=798 → 799 → 0 with v_count=10 → 11; line_start pulses one HCLK; at h_count=797, h_ahead=0 and v_ahead=11.
- enable held 0 for 37 HCLK mid-line: all outputs unchanged; divider phase resumes where it stopped.
- CLK_DIV=1, LOOKAHEAD=0, TILE_LOG2=3: pix_ce constantly 1; h_ahead=h_count; at h_count=100, tile_col=12 and sub_x=4.
- HRESETn pulsed low at h_count=400, v_count=300: outputs take the REQ-016 values immediately; frame_count=0; no spurious frame_start after release.
- frame_count forced near wrap (65535 frames, or a reduced-timing build): the next frame wrap gives frame_count=0.
